// File: rtl/task_enqueue.sv
// rtl/task_enqueue.sv - host push/pop request admission into per-level task FIFOs
//
// Host side: one request per cycle (i_push or i_pop) tagged with i_treeId.
// The request goes to FIFO (i_treeId mod LEVEL). o_ready reflects that FIFO's
// full flag. The request is admitted when it is valid, ready and legal against
// the per-tree element count. o_err pulses for one cycle after a rejected request.
//
// Ports:
//   i_clk, i_arst_n        clock, asynchronous active-low reset
//   i_push, i_pop          host request strobes (exactly one = valid)
//   i_treeId               target tree
//   i_push_data            payload for pushes
//   o_ready                target FIFO not full
//   o_err                  registered reject pulse
//   i_pop_TaskFIFO         per-FIFO pop from the distributor
//   o_TaskFIFO_data        per-FIFO registered popped task word {type, treeId, data}
//   o_TaskFIFO_empty       per-FIFO empty
//   o_tree_empty           per-tree count == 0
module task_enqueue #(
    parameter int PTW        = 16,
    parameter int MTW        = 16,
    parameter int LEVEL      = 4,
    parameter int TREE_NUM   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TREE_CAP   = 15,
    localparam int LEVEL_BITS    = $clog2(LEVEL),
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int TDB           = PTW + MTW + TREE_NUM_BITS,
    localparam int CNT_BITS      = $clog2(TREE_CAP + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_arst_n,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [TREE_NUM_BITS-1:0]       i_treeId,
    input  logic [PTW+MTW-1:0]             i_push_data,
    output logic                           o_ready,
    output logic                           o_err,
    input  logic [LEVEL-1:0]               i_pop_TaskFIFO,
    output logic [LEVEL-1:0][TDB:0]        o_TaskFIFO_data,
    output logic [LEVEL-1:0]               o_TaskFIFO_empty,
    output logic [TREE_NUM-1:0]            o_tree_empty
);

    localparam int AB = $clog2(FIFO_DEPTH);
    localparam int PB = AB + 1;
    localparam logic [CNT_BITS-1:0] CAP = CNT_BITS'(TREE_CAP);

    logic [LEVEL-1:0]          w_full;
    logic [LEVEL-1:0]          w_empty;
    logic [LEVEL_BITS-1:0]     w_f;
    logic                      w_valid;
    logic                      w_legal;
    logic                      w_accept;
    logic                      w_reject;
    logic [TDB:0]              w_word;
    logic [CNT_BITS-1:0]       w_cnt_sel;

    logic [CNT_BITS-1:0]       r_cnt [TREE_NUM];
    logic                      r_err;

    assign w_f       = i_treeId[LEVEL_BITS-1:0];
    assign w_cnt_sel = r_cnt[i_treeId];
    assign o_ready   = ~w_full[w_f];
    assign w_valid   = i_push ^ i_pop;
    assign w_legal   = i_push ? (w_cnt_sel < CAP) : (w_cnt_sel != '0);
    assign w_accept  = w_valid & o_ready & w_legal;
    // A valid request blocked only by a full FIFO is a stall, not an error.
    assign w_reject  = (i_push & i_pop) | (w_valid & o_ready & ~w_legal);
    assign w_word    = {i_push, i_treeId, (i_push ? i_push_data : {(PTW+MTW){1'b0}})};
    assign o_err     = r_err;
    assign o_TaskFIFO_empty = w_empty;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_err <= 1'b0;
            for (int t = 0; t < TREE_NUM; t++) begin
                r_cnt[t] <= '0;
            end
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_cnt[i_treeId] <= i_push ? (w_cnt_sel + CNT_BITS'(1))
                                          : (w_cnt_sel - CNT_BITS'(1));
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < TREE_NUM; g++) begin : gen_tree
            assign o_tree_empty[g] = (r_cnt[g] == '0);
        end

        for (g = 0; g < LEVEL; g++) begin : gen_fifo
            localparam logic [LEVEL_BITS-1:0] IDX = LEVEL_BITS'(g);

            logic [TDB:0]  r_mem [FIFO_DEPTH];
            logic [PB-1:0] r_wptr;
            logic [PB-1:0] r_rptr;
            logic [TDB:0]  r_data;
            logic          w_wr;
            logic          w_rd;

            assign w_empty[g] = (r_wptr == r_rptr);
            assign w_full[g]  = (r_wptr[PB-1] != r_rptr[PB-1]) &&
                                (r_wptr[AB-1:0] == r_rptr[AB-1:0]);
            assign w_wr = w_accept && (w_f == IDX);
            // Emptiness is judged before this cycle's write, so a pop on an
            // empty FIFO is dropped even when a write lands the same edge.
            assign w_rd = i_pop_TaskFIFO[g] && !w_empty[g];
            assign o_TaskFIFO_data[g] = r_data;

            always_ff @(posedge i_clk) begin
                if (w_wr) begin
                    r_mem[r_wptr[AB-1:0]] <= w_word;
                end
            end

            always_ff @(posedge i_clk or negedge i_arst_n) begin
                if (!i_arst_n) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_data <= '0;
                end else begin
                    if (w_wr) begin
                        r_wptr <= r_wptr + PB'(1);
                    end
                    if (w_rd) begin
                        r_data <= r_mem[r_rptr[AB-1:0]];
                        r_rptr <= r_rptr + PB'(1);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_task_enqueue.sv
// tb/tb_task_enqueue.sv - randomized self-checking bench for task_enqueue
module tb_task_enqueue;

    localparam int PTW        = 16;
    localparam int MTW        = 16;
    localparam int LEVEL      = 4;
    localparam int TREE_NUM   = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int TREE_CAP   = 15;
    localparam int TNB        = $clog2(TREE_NUM);
    localparam int TDB        = PTW + MTW + TNB;

    logic                     clk = 1'b0;
    logic                     arst_n = 1'b0;
    logic                     push = 1'b0;
    logic                     pop = 1'b0;
    logic [TNB-1:0]           tree_id = '0;
    logic [PTW+MTW-1:0]       push_data = '0;
    logic                     ready;
    logic                     err;
    logic [LEVEL-1:0]         dist_pop = '0;
    logic [LEVEL-1:0][TDB:0]  fifo_data;
    logic [LEVEL-1:0]         fifo_empty;
    logic [TREE_NUM-1:0]      tree_empty;

    task_enqueue #(
        .PTW(PTW), .MTW(MTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM),
        .FIFO_DEPTH(FIFO_DEPTH), .TREE_CAP(TREE_CAP)
    ) dut (
        .i_clk(clk),
        .i_arst_n(arst_n),
        .i_push(push),
        .i_pop(pop),
        .i_treeId(tree_id),
        .i_push_data(push_data),
        .o_ready(ready),
        .o_err(err),
        .i_pop_TaskFIFO(dist_pop),
        .o_TaskFIFO_data(fifo_data),
        .o_TaskFIFO_empty(fifo_empty),
        .o_tree_empty(tree_empty)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues of task words and per-tree counts.
    logic [TDB:0] q [LEVEL][$];
    int           cnt [TREE_NUM];
    logic [TDB:0] exp_data [LEVEL];
    bit           exp_err;

    int checks = 0;
    int errors = 0;
    int n_err_seen = 0;
    int n_stall_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LEVEL; i++) begin
            q[i].delete();
            exp_data[i] = '0;
        end
        for (int t = 0; t < TREE_NUM; t++) cnt[t] = 0;
        exp_err = 1'b0;
    endtask

    task automatic check_state();
        for (int i = 0; i < LEVEL; i++) begin
            check($sformatf("data%0d", i), 64'(fifo_data[i]), 64'(exp_data[i]));
            check($sformatf("empty%0d", i), 64'(fifo_empty[i]), 64'(q[i].size() == 0));
        end
        for (int t = 0; t < TREE_NUM; t++)
            check($sformatf("tree_empty%0d", t), 64'(tree_empty[t]), 64'(cnt[t] == 0));
        check("err", 64'(err), 64'(exp_err));
    endtask

    // One cycle: check registered state, drive random request, check o_ready,
    // then advance the model by what the coming edge should do.
    task automatic step(input int p_push, input int p_pop, input int p_dist);
        int r, f, t;
        bit want_push, want_pop, valid, rdy, legal, acc;
        logic [TDB:0] w;
        @(negedge clk);
        check_state();
        r = $urandom_range(99);
        want_push = (r < p_push) || (r >= 97);
        want_pop  = ((r >= p_push) && (r < p_push + p_pop)) || (r >= 97);
        push = want_push;
        pop  = want_pop;
        t = $urandom_range(TREE_NUM - 1);
        tree_id = TNB'(t);
        push_data = $urandom;
        for (int i = 0; i < LEVEL; i++) dist_pop[i] = ($urandom_range(99) < p_dist);
        #1;
        f = t % LEVEL;
        rdy = (q[f].size() < FIFO_DEPTH);
        check("ready", 64'(ready), 64'(rdy));
        valid = want_push ^ want_pop;
        legal = want_push ? (cnt[t] < TREE_CAP) : (cnt[t] > 0);
        acc = valid && rdy && legal;
        exp_err = (want_push && want_pop) || (valid && rdy && !legal);
        if (exp_err) n_err_seen++;
        if (valid && !rdy) n_stall_seen++;
        for (int i = 0; i < LEVEL; i++)
            if (dist_pop[i] && q[i].size() > 0) exp_data[i] = q[i].pop_front();
        if (acc) begin
            w = {want_push, TNB'(t), (want_push ? push_data : {(PTW+MTW){1'b0}})};
            q[f].push_back(w);
            cnt[t] = cnt[t] + (want_push ? 1 : -1);
        end
    endtask

    task automatic idle_inputs();
        push = 1'b0;
        pop = 1'b0;
        dist_pop = '0;
        tree_id = '0;
        push_data = '0;
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_state();
        check("ready_rst", 64'(ready), 64'd1);
        @(negedge clk);
        arst_n = 1'b1;

        // Push-heavy with a slow distributor: fills FIFOs and reaches tree cap.
        repeat (400) step(80, 10, 10);
        // Balanced traffic: pointer wrap and mixed push/pop words.
        repeat (400) step(45, 40, 50);
        // Pop-heavy: drains counts to zero and hits pop-at-zero rejects.
        repeat (300) step(15, 75, 70);

        // Asynchronous reset with tasks still queued.
        repeat (60) step(90, 0, 0);
        @(negedge clk);
        check_state();
        idle_inputs();
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        model_clear();
        check_state();
        check("ready_arst", 64'(ready), 64'd1);
        @(negedge clk);
        arst_n = 1'b1;

        repeat (400) step(50, 35, 40);

        @(negedge clk);
        check_state();
        idle_inputs();
        check("saw_reject", 64'(n_err_seen > 0), 64'd1);
        check("saw_stall", 64'(n_stall_seen > 0), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
